// File: rtl/console_pkg.sv
// Shared constants for the text console: geometry defaults, control codes,
// FSM encoding and the VRAM word layout. Optional scroll states: VRAM_CONSOLE_SCROLL_EN.
package console_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 50;

    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    // Word layout read by the display side: {4'h0, color[11:0], 9'h0, char[6:0]}
    localparam int WORD_CHAR_LSB  = 0;
    localparam int WORD_CHAR_W    = 7;
    localparam int WORD_COLOR_LSB = 16;
    localparam int WORD_COLOR_W   = 12;

    typedef enum logic [2:0] {
        CUR_NONE = 3'd0,
        CUR_ADV  = 3'd1,
        CUR_NL   = 3'd2,
        CUR_CR   = 3'd3,
        CUR_BS   = 3'd4,
        CUR_HOME = 3'd5
    } cursor_cmd_e;

`ifdef VRAM_CONSOLE_SCROLL_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SCR_RD = 3'd2,
        ST_SCR_WR = 3'd3,
        ST_BLANK  = 3'd4
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;
`endif

    function automatic logic [31:0] pack_word(input logic [11:0] color, input logic [6:0] ch);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[WORD_COLOR_LSB +: WORD_COLOR_W] = color;
        w[WORD_CHAR_LSB +: WORD_CHAR_W]   = ch;
        return w;
    endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor row/column counters with advance, newline, backspace and home handling.
// Last-row newline holds the row under VRAM_CONSOLE_SCROLL_EN, otherwise wraps to row 0.
module console_cursor
    import console_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic        clk,
    input  logic        clrn,
    input  cursor_cmd_e cmd,
    output logic [5:0]  row,
    output logic [6:0]  col,
    output logic        last_nl
);

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

    logic [6:0] col_adv_s;
    logic [6:0] col_nxt_s;
    logic [5:0] row_nxt_s;
    logic       nl_s;
    logic       home_s;

    // Next cursor position for the command presented this cycle
    always_comb begin
        col_adv_s = col;
        nl_s      = 1'b0;
        home_s    = 1'b0;
        case (cmd)
            CUR_ADV: begin
                if (col == COL_LAST) begin
                    nl_s = 1'b1;
                end else begin
                    col_adv_s = col + 7'd1;
                end
            end
            CUR_NL:   nl_s = 1'b1;
            CUR_CR:   col_adv_s = 7'd0;
            CUR_BS: begin
                if (col != 7'd0) begin
                    col_adv_s = col - 7'd1;
                end else begin
                    col_adv_s = col;
                end
            end
            CUR_HOME: home_s = 1'b1;
            default:  col_adv_s = col;
        endcase

        if (home_s) begin
            row_nxt_s = 6'd0;
            col_nxt_s = 7'd0;
        end else if (nl_s) begin
            col_nxt_s = 7'd0;
            if (row != ROW_LAST) begin
                row_nxt_s = row + 6'd1;
            end else begin
`ifdef VRAM_CONSOLE_SCROLL_EN
                row_nxt_s = ROW_LAST;
`else
                row_nxt_s = 6'd0;
`endif
            end
        end else begin
            row_nxt_s = row;
            col_nxt_s = col_adv_s;
        end
    end

    assign last_nl = nl_s & (row == ROW_LAST);

    // Cursor position registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            row <= 6'd0;
            col <= 7'd0;
        end else begin
            row <= row_nxt_s;
            col <= col_nxt_s;
        end
    end

endmodule

// File: rtl/vram_console.sv
// Character-stream console writing RGB444-colored glyph codes into a text VRAM.
// Define VRAM_CONSOLE_SCROLL_EN to scroll on last-row newline instead of wrapping.
module vram_console
    import console_pkg::*;
#(
    parameter int         COLS       = COLS_DEF,
    parameter int         ROWS       = ROWS_DEF,
    parameter logic [6:0] BLANK_CHAR = 7'h20
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    input  logic        color_we,
    input  logic [11:0] color_in,
    output logic [11:0] vram_addr,
    output logic        vram_we,
    output logic [31:0] vram_wdata,
    input  logic [31:0] vram_rdata,
    output logic [5:0]  cursor_row,
    output logic [6:0]  cursor_col
);

    localparam logic [11:0] CELLS_LAST = 12'(ROWS * COLS - 1);
`ifdef VRAM_CONSOLE_SCROLL_EN
    localparam logic [11:0] SCR_LAST      = 12'((ROWS - 1) * COLS - 1);
    localparam logic [11:0] LAST_ROW_BASE = 12'((ROWS - 1) * COLS);
    localparam logic [11:0] COLS_W12      = 12'(COLS);
    logic rd_wait_r;
`endif

    state_e      state_r;
    logic [11:0] cnt_r;
    logic [11:0] color_r;
    logic        acc_s;
    logic        wr_char_s;
    logic        wr_bs_s;
    logic        go_clear_s;
    logic        last_nl_s;
    cursor_cmd_e cur_cmd_s;
    logic [11:0] cur_addr_s;
    logic [11:0] bs_addr_s;

    assign ch_ready   = (state_r == ST_IDLE);
    assign acc_s      = ch_valid & ch_ready;
    assign cur_addr_s = 12'(int'(cursor_row) * COLS + int'(cursor_col));
    assign bs_addr_s  = cur_addr_s - 12'd1;

`ifndef VRAM_CONSOLE_SCROLL_EN
    logic unused_s;
    assign unused_s = ^{vram_rdata, last_nl_s};
`endif

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk     (clk),
        .clrn    (clrn),
        .cmd     (cur_cmd_s),
        .row     (cursor_row),
        .col     (cursor_col),
        .last_nl (last_nl_s)
    );

    // Decode an accepted character into a cursor command and a VRAM action
    always_comb begin
        cur_cmd_s  = CUR_NONE;
        wr_char_s  = 1'b0;
        wr_bs_s    = 1'b0;
        go_clear_s = 1'b0;
        if (acc_s) begin
            if ((ch_data >= CH_PRINT_LO) && (ch_data <= CH_PRINT_HI)) begin
                cur_cmd_s = CUR_ADV;
                wr_char_s = 1'b1;
            end else begin
                case (ch_data)
                    CH_LF: cur_cmd_s = CUR_NL;
                    CH_CR: cur_cmd_s = CUR_CR;
                    CH_BS: begin
                        if (cursor_col != 7'd0) begin
                            cur_cmd_s = CUR_BS;
                            wr_bs_s   = 1'b1;
                        end else begin
                            cur_cmd_s = CUR_NONE;
                        end
                    end
                    CH_FF: begin
                        cur_cmd_s  = CUR_HOME;
                        go_clear_s = 1'b1;
                    end
                    default: cur_cmd_s = CUR_NONE;
                endcase
            end
        end else begin
            cur_cmd_s = CUR_NONE;
        end
    end

    // Current drawing color; a same-cycle character still sees the old value
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            color_r <= 12'hFFF;
        end else if (color_we) begin
            color_r <= color_in;
        end else begin
            color_r <= color_r;
        end
    end

    // Control FSM driving the registered VRAM port
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r    <= ST_CLEAR;
            cnt_r      <= 12'd0;
            vram_we    <= 1'b0;
            vram_addr  <= 12'd0;
            vram_wdata <= 32'd0;
`ifdef VRAM_CONSOLE_SCROLL_EN
            rd_wait_r  <= 1'b0;
`endif
        end else begin
            vram_we <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wr_char_s || wr_bs_s) begin
                        vram_we    <= 1'b1;
                        vram_addr  <= wr_bs_s ? bs_addr_s : cur_addr_s;
                        vram_wdata <= pack_word(color_r, wr_bs_s ? BLANK_CHAR : ch_data[6:0]);
                    end
                    if (go_clear_s) begin
                        state_r <= ST_CLEAR;
                        cnt_r   <= 12'd0;
`ifdef VRAM_CONSOLE_SCROLL_EN
                    end else if (last_nl_s) begin
                        state_r <= ST_SCR_RD;
                        cnt_r   <= 12'd0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    vram_we    <= 1'b1;
                    vram_addr  <= cnt_r;
                    vram_wdata <= pack_word(color_r, BLANK_CHAR);
                    if (cnt_r == CELLS_LAST) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 12'd0;
                    end else begin
                        cnt_r <= cnt_r + 12'd1;
                    end
                end
`ifdef VRAM_CONSOLE_SCROLL_EN
                ST_SCR_RD: begin
                    vram_addr <= cnt_r + COLS_W12;
                    rd_wait_r <= 1'b1;
                    state_r   <= ST_SCR_WR;
                end
                // First cycle waits out the read latency, second copies the word down
                ST_SCR_WR: begin
                    if (rd_wait_r) begin
                        rd_wait_r <= 1'b0;
                    end else begin
                        vram_we    <= 1'b1;
                        vram_addr  <= cnt_r;
                        vram_wdata <= vram_rdata;
                        if (cnt_r == SCR_LAST) begin
                            cnt_r   <= LAST_ROW_BASE;
                            state_r <= ST_BLANK;
                        end else begin
                            cnt_r   <= cnt_r + 12'd1;
                            state_r <= ST_SCR_RD;
                        end
                    end
                end
                ST_BLANK: begin
                    vram_we    <= 1'b1;
                    vram_addr  <= cnt_r;
                    vram_wdata <= pack_word(color_r, BLANK_CHAR);
                    if (cnt_r == CELLS_LAST) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 12'd0;
                    end else begin
                        cnt_r <= cnt_r + 12'd1;
                    end
                end
`endif
                default: begin
                    state_r <= ST_CLEAR;
                    cnt_r   <= 12'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_console.sv
// Self-checking bench: randomized character stream against a screen/cursor model.
// Honors VRAM_CONSOLE_SCROLL_EN for last-row newline expectations.
module tb_vram_console;

    localparam int COLS  = 80;
    localparam int ROWS  = 50;
    localparam int CELLS = COLS * ROWS;

    logic        clk;
    logic        clrn;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        color_we;
    logic [11:0] color_in;
    logic [11:0] vram_addr;
    logic        vram_we;
    logic [31:0] vram_wdata;
    logic [31:0] vram_rdata;
    logic [5:0]  cursor_row;
    logic [6:0]  cursor_col;

    vram_console #(.COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(7'h20)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .color_we   (color_we),
        .color_in   (color_in),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clk = ~clk;

    // VRAM: synchronous read one cycle after address, write on strobe
    logic [31:0] mem [0:4095];
    int          wr_cnt = 0;
    int          mark   = 0;
    logic [11:0] first_addr = 12'd0;
    logic [11:0] last_addr  = 12'd0;
    logic [31:0] last_wdata = 32'd0;

    always @(posedge clk) begin
        vram_rdata <= mem[vram_addr];
        if (vram_we) begin
            mem[vram_addr] <= vram_wdata;
            wr_cnt         <= wr_cnt + 1;
            last_addr      <= vram_addr;
            last_wdata     <= vram_wdata;
            if (wr_cnt == mark) first_addr <= vram_addr;
        end
    end

    // Reference model
    int          n_err = 0;
    int          n_chk = 0;
    int          m_row, m_col, exp_wr;
    logic [11:0] m_color;
    logic [31:0] scr [0:CELLS-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [11:0] c, input logic [7:0] ch);
        return {4'h0, c, 9'h000, ch[6:0]};
    endfunction

    task automatic model_blank_all();
        for (int i = 0; i < CELLS; i++) scr[i] = word_of(m_color, 8'h20);
    endtask

    task automatic model_newline();
        m_col = 0;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
`ifdef VRAM_CONSOLE_SCROLL_EN
            for (int i = 0; i < CELLS - COLS; i++) scr[i] = scr[i + COLS];
            for (int i = CELLS - COLS; i < CELLS; i++) scr[i] = word_of(m_color, 8'h20);
            exp_wr += CELLS;
`else
            m_row = 0;
`endif
        end
    endtask

    task automatic model_apply(input logic [7:0] c);
        exp_wr = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            scr[m_row * COLS + m_col] = word_of(m_color, c);
            exp_wr = 1;
            m_col++;
            if (m_col == COLS) model_newline();
        end else if (c == 8'h0A) begin
            model_newline();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                scr[m_row * COLS + m_col] = word_of(m_color, 8'h20);
                exp_wr = 1;
            end
        end else if (c == 8'h0C) begin
            m_row = 0;
            m_col = 0;
            model_blank_all();
            exp_wr = CELLS;
        end
    endtask

    task automatic model_reset();
        m_row   = 0;
        m_col   = 0;
        m_color = 12'hFFF;
        model_blank_all();
    endtask

    function automatic int screen_diffs();
        int d = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== scr[i]) d++;
        return d;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ch_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_ready"}, 32'(ch_ready), 32'd1);
    endtask

    task automatic check_cursor(input string tag);
        check_val({tag, "_row"}, 32'(cursor_row), 32'(m_row));
        check_val({tag, "_col"}, 32'(cursor_col), 32'(m_col));
    endtask

    task automatic send(input logic [7:0] c, input logic cwe, input logic [11:0] cv);
        int base;
        base     = wr_cnt;
        mark     = wr_cnt;
        ch_valid = 1'b1;
        ch_data  = c;
        color_we = cwe;
        color_in = cv;
        @(negedge clk);
        ch_valid = 1'b0;
        color_we = 1'b0;
        model_apply(c);
        if (cwe) m_color = cv;
        wait_ready("send");
        repeat (2) @(negedge clk);
        check_val($sformatf("wr_cnt_%02h", c), 32'(wr_cnt - base), 32'(exp_wr));
        check_cursor($sformatf("cur_%02h", c));
    endtask

    task automatic set_color(input logic [11:0] cv);
        color_we = 1'b1;
        color_in = cv;
        @(negedge clk);
        color_we = 1'b0;
        m_color  = cv;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_we"}, 32'(vram_we), 32'd0);
        check_val({tag, "_addr"}, 32'(vram_addr), 32'd0);
        check_val({tag, "_wdata"}, vram_wdata, 32'd0);
        check_val({tag, "_ready"}, 32'(ch_ready), 32'd0);
        check_val({tag, "_row"}, 32'(cursor_row), 32'd0);
        check_val({tag, "_col"}, 32'(cursor_col), 32'd0);
    endtask

    task automatic release_and_clear(input string tag);
        int base;
        @(negedge clk);
        base = wr_cnt;
        mark = wr_cnt;
        clrn = 1'b1;
        model_reset();
        wait_ready(tag);
        repeat (2) @(negedge clk);
        check_val({tag, "_writes"}, 32'(wr_cnt - base), 32'(CELLS));
        check_val({tag, "_first"}, 32'(first_addr), 32'd0);
        check_val({tag, "_last"}, 32'(last_addr), 32'(CELLS - 1));
        check_val({tag, "_lastw"}, last_wdata, 32'h0FFF0020);
        check_val({tag, "_screen"}, 32'(screen_diffs()), 32'd0);
        check_cursor(tag);
    endtask

    initial begin
        int r;
        logic [7:0] c;
        clk      = 1'b0;
        clrn     = 1'b0;
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        color_we = 1'b0;
        color_in = 12'h000;
        #12;
        check_reset_outputs("rst");
        release_and_clear("clr");

        // Colored character and same-cycle color update
        set_color(12'hF00);
        send(8'h41, 1'b0, 12'h000);
        check_val("A_addr", 32'(last_addr), 32'd0);
        check_val("A_wdata", last_wdata, 32'h0F000041);
        send(8'h42, 1'b1, 12'h0F0);
        check_val("B_old_color", last_wdata, 32'h0F000042);
        send(8'h43, 1'b0, 12'h000);
        check_val("C_new_color", last_wdata, 32'h00F00043);

        // Form feed, line wrap and backspace boundaries
        send(8'h0C, 1'b0, 12'h000);
        check_val("ff_screen", 32'(screen_diffs()), 32'd0);
        for (int i = 0; i < 81; i++) send(8'h78, 1'b0, 12'h000);
        check_val("x81_addr", 32'(last_addr), 32'd80);
        send(8'h08, 1'b0, 12'h000);
        check_val("bs_addr", 32'(last_addr), 32'd80);
        check_val("bs_wdata", last_wdata, 32'h00F00020);
        send(8'h08, 1'b0, 12'h000);
        send(8'h0D, 1'b0, 12'h000);
        send(8'h07, 1'b0, 12'h000);
        send(8'hC1, 1'b0, 12'h000);

        // Random stream
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                c = 8'($urandom_range(32, 126));
                send(c, 1'b0, 12'h000);
            end else if (r < 80) begin
                send(8'h0A, 1'b0, 12'h000);
            end else if (r < 85) begin
                send(8'h0D, 1'b0, 12'h000);
            end else if (r < 92) begin
                send(8'h08, 1'b0, 12'h000);
            end else if (r < 96) begin
                c = 8'($urandom_range(0, 1) != 0 ? 32'h07 : (32'h80 | $urandom_range(0, 127)));
                send(c, 1'b0, 12'h000);
            end else begin
                c = 8'($urandom_range(32, 126));
                send(c, 1'b1, 12'($urandom_range(0, 4095)));
            end
        end
        check_val("rand_screen", 32'(screen_diffs()), 32'd0);

        // Newline on the last row
        while (m_row != ROWS - 1) send(8'h0A, 1'b0, 12'h000);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(33, 126)), 1'b0, 12'h000);
        send(8'h0A, 1'b0, 12'h000);
        check_val("last_nl_screen", 32'(screen_diffs()), 32'd0);

        // Reset pulse while a last-row newline is in progress
        while (m_row != ROWS - 1) send(8'h0A, 1'b0, 12'h000);
        ch_valid = 1'b1;
        ch_data  = 8'h0A;
        @(negedge clk);
        ch_valid = 1'b0;
        repeat (100) @(negedge clk);
        #2 clrn = 1'b0;
        #1 check_reset_outputs("midrst");
        release_and_clear("reclr");
        send(8'h71, 1'b0, 12'h000);
        send(8'h71, 1'b0, 12'h000);
        send(8'h07, 1'b0, 12'h000);
        check_val("bel_screen", 32'(screen_diffs()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
